// File: rtl/vscale_pc_redirect_if.sv
// Fetch-stage redirect bundle: request/qualifier inputs, next-PC from the mux,
// and the select/PC/kill/status outputs of the redirect controller.
interface vscale_pc_redirect_if #(
  parameter int unsigned XPR_LEN          = 32,
  parameter int unsigned PC_SRC_SEL_WIDTH = 3,
  parameter int unsigned CNT_WIDTH        = 16
);

  // Requests and qualifiers
  logic                        imem_wait;
  logic                        stall_DX;
  logic                        trap_req;
  logic                        eret_req;
  logic                        jalr_DX;
  logic                        jal_DX;
  logic                        branch_taken_DX;
  // Next PC computed by the external mux for the select driven this cycle
  logic [XPR_LEN-1:0]          PC_PIF;

  // Controller outputs
  logic [PC_SRC_SEL_WIDTH-1:0] PC_src_sel;
  logic [XPR_LEN-1:0]          PC_IF;
  logic                        kill_DX;
  logic                        redirect_pending;
  logic [CNT_WIDTH-1:0]        redirect_cnt;

  // Pipeline / environment side
  modport master (
    output imem_wait,
    output stall_DX,
    output trap_req,
    output eret_req,
    output jalr_DX,
    output jal_DX,
    output branch_taken_DX,
    output PC_PIF,
    input  PC_src_sel,
    input  PC_IF,
    input  kill_DX,
    input  redirect_pending,
    input  redirect_cnt
  );

  // Redirect controller side
  modport slave (
    input  imem_wait,
    input  stall_DX,
    input  trap_req,
    input  eret_req,
    input  jalr_DX,
    input  jal_DX,
    input  branch_taken_DX,
    input  PC_PIF,
    output PC_src_sel,
    output PC_IF,
    output kill_DX,
    output redirect_pending,
    output redirect_cnt
  );

endinterface

// File: rtl/vscale_pc_redirect_ctrl.sv
// vscale fetch-stage PC redirect controller.
// Arbitrates trap/eret/DX redirects, drives the PC source mux select, owns PC_IF,
// parks a redirect target while imem is busy, kills the wrong-path instruction
// and counts committed redirects (saturating).
module vscale_pc_redirect_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h200,
  parameter int unsigned CNT_WIDTH = 16
) (
  input logic                   clk,
  input logic                   reset,
  vscale_pc_redirect_if.slave   bus
);

  // PC mux select encodings (vscale_ctrl_constants.vh)
  localparam logic [2:0] PC_PLUS_FOUR     = 3'd0;
  localparam logic [2:0] PC_BRANCH_TARGET = 3'd1;
  localparam logic [2:0] PC_JAL_TARGET    = 3'd2;
  localparam logic [2:0] PC_JALR_TARGET   = 3'd3;
  localparam logic [2:0] PC_REPLAY        = 3'd4;
  localparam logic [2:0] PC_HANDLER       = 3'd5;
  localparam logic [2:0] PC_EPC           = 3'd6;

  typedef enum logic [0:0] {
    StRun  = 1'b0,
    StHold = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [31:0]          pc_if_q, pc_if_d;
  logic [31:0]          pend_pc_q, pend_pc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [2:0]           sel;
  logic                 kill;
  logic                 pending;

  // DX-originated requests only count when DX is not stalled
  logic                 jalr_q_ok, jal_q_ok, br_q_ok;
  logic                 dx_req, any_req;
  logic [CNT_WIDTH-1:0] cnt_inc;

  assign jalr_q_ok = bus.jalr_DX         & ~bus.stall_DX;
  assign jal_q_ok  = bus.jal_DX          & ~bus.stall_DX;
  assign br_q_ok   = bus.branch_taken_DX & ~bus.stall_DX;
  assign dx_req    = jalr_q_ok | jal_q_ok | br_q_ok;
  assign any_req   = bus.trap_req | bus.eret_req | dx_req;

  // Saturate at all-ones rather than wrapping
  assign cnt_inc = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + CNT_WIDTH'(1);

  // State, fetch PC, parked target and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StRun;
      pc_if_q   <= RESET_PC;
      pend_pc_q <= 32'h0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_if_q   <= pc_if_d;
      pend_pc_q <= pend_pc_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state, mux select, kill and pending decode
  always_comb begin
    state_d   = state_q;
    pc_if_d   = pc_if_q;
    pend_pc_d = pend_pc_q;
    cnt_d     = cnt_q;
    sel       = PC_REPLAY;
    kill      = 1'b0;
    pending   = 1'b0;

    unique case (state_q)
      StRun: begin
        // Fixed priority: trap > eret > jalr > jal > branch
        if (bus.trap_req) begin
          sel = PC_HANDLER;
        end else if (bus.eret_req) begin
          sel = PC_EPC;
        end else if (jalr_q_ok) begin
          sel = PC_JALR_TARGET;
        end else if (jal_q_ok) begin
          sel = PC_JAL_TARGET;
        end else if (br_q_ok) begin
          sel = PC_BRANCH_TARGET;
        end else if (bus.imem_wait | bus.stall_DX) begin
          sel = PC_REPLAY;
        end else begin
          sel = PC_PLUS_FOUR;
        end

        if (any_req) begin
          kill  = 1'b1;
          cnt_d = cnt_inc;
          if (bus.imem_wait) begin
            // Fetch not accepted: park the target until imem frees up
            pend_pc_d = bus.PC_PIF;
            state_d   = StHold;
          end else begin
            pc_if_d = bus.PC_PIF;
          end
        end else if (!bus.imem_wait && !bus.stall_DX) begin
          pc_if_d = bus.PC_PIF;
        end
      end

      StHold: begin
        pending = 1'b1;
        kill    = 1'b1;
        // Only a trap can override a parked redirect
        if (bus.trap_req) begin
          sel       = PC_HANDLER;
          pend_pc_d = bus.PC_PIF;
          cnt_d     = cnt_inc;
        end else begin
          sel = PC_REPLAY;
        end

        if (!bus.imem_wait) begin
          pc_if_d = bus.trap_req ? bus.PC_PIF : pend_pc_q;
          state_d = StRun;
        end
      end

      default: begin
        state_d = StRun;
      end
    endcase
  end

  // Combinational outputs are forced to their idle values while reset is held
  always_comb begin
    bus.PC_src_sel       = reset ? PC_REPLAY : sel;
    bus.kill_DX          = reset ? 1'b0 : kill;
    bus.redirect_pending = reset ? 1'b0 : pending;
  end

  assign bus.PC_IF        = pc_if_q;
  assign bus.redirect_cnt = cnt_q;

endmodule

// File: doc/vscale_pc_redirect_ctrl.md
Name: vscale_pc_redirect_ctrl

Overview:
- Sequences the PC source mux and owns the PC_IF register for the vscale fetch stage.
- Arbitrates concurrent redirect requests from the DX stage and the CSR/trap unit, and drives PC_src_sel.
- Latches redirect targets that arrive while instruction memory is busy, and holds them until the fetch is accepted.
- Generates the kill signal for the wrong-path instruction and keeps a saturating redirect count for performance monitoring.

Parameters:
RESET_PC, 32'h200, PC_IF value loaded on reset.
CNT_WIDTH, 16, width of redirect_cnt.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
imem_wait  in  1  instruction memory not ready; fetch at PC_IF not accepted this cycle
stall_DX  in  1  DX stage stalled; suppresses DX-originated redirects and PC advance
trap_req  in  1  exception/interrupt taken; redirect to handler_PC
eret_req  in  1  return from trap; redirect to epc
jalr_DX  in  1  JALR in DX
jal_DX  in  1  JAL in DX
branch_taken_DX  in  1  taken conditional branch in DX
PC_PIF  in  XPR_LEN  next-PC result from the PC mux for the PC_src_sel driven this cycle
PC_src_sel  out  PC_SRC_SEL_WIDTH  mux select; encodings are the PC_* constants in vscale_ctrl_constants.vh
PC_IF  out  XPR_LEN  registered fetch PC
kill_DX  out  1  squash the instruction entering DX
redirect_pending  out  1  high in HOLD
redirect_cnt  out  CNT_WIDTH  committed redirects, saturating

Behaviour:
- Reset is asynchronous and active-high. On reset: PC_IF=RESET_PC, state=RUN, pend_PC=0, redirect_cnt=0.
- All outputs are low/zero during reset, except PC_IF=RESET_PC and PC_src_sel=PC_REPLAY.
- Redirect request priority: trap_req > eret_req > jalr_DX > jal_DX > branch_taken_DX.
- jalr_DX, jal_DX and branch_taken_DX are qualified by !stall_DX. trap_req and eret_req are never qualified.
- Select mapping: trap→PC_HANDLER, eret→PC_EPC, jalr→PC_JALR_TARGET, jal→PC_JAL_TARGET, branch→PC_BRANCH_TARGET.
- With no request: PC_REPLAY if imem_wait|stall_DX, else PC_PLUS_FOUR.
- PC_src_sel is combinational from state and inputs.
- State RUN:
  - Redirect, !imem_wait: PC_IF<=PC_PIF next edge; kill_DX=1 this cycle; redirect_cnt++.
  - Redirect, imem_wait: pend_PC<=PC_PIF; go to HOLD; kill_DX=1; redirect_cnt++ (counted at capture).
  - No redirect, !imem_wait, !stall_DX: PC_IF<=PC_PIF (PC_IF+4).
  - Otherwise PC_IF holds.
- State HOLD:
  - redirect_pending=1, kill_DX=1.
  - DX-originated requests and eret_req are ignored.
  - trap_req: PC_src_sel=PC_HANDLER, pend_PC<=PC_PIF, redirect_cnt++.
  - PC_src_sel=PC_REPLAY otherwise.
  - When !imem_wait: PC_IF<=pend_PC, or PC_PIF if trap_req occurs in that same cycle. Return to RUN.
  - Minimum HOLD occupancy is 1 cycle.
- Redirect-to-fetch latency: 1 cycle with no wait, 1+N cycles with N wait cycles.
- redirect_cnt saturates at all-ones and does not wrap.
- PC arithmetic is performed by the mux. This block adds nothing; PC_IF wraps modulo 2^XPR_LEN as delivered by PC_PIF.
- Simultaneous trap_req and eret_req: trap wins; eret is dropped.
- Reset asserted mid-HOLD discards pend_PC immediately.

Test Plan:
- Reset release, no stimulus, imem_wait=0 → PC_IF sequence 0x200, 0x204, 0x208; PC_src_sel=PC_PLUS_FOUR; kill_DX=0.
- jal_DX=1 for one cycle with PC_PIF=0x340, imem_wait=0 → PC_src_sel=PC_JAL_TARGET; kill_DX=1 that cycle; PC_IF=0x340 next; redirect_cnt=1.
- branch_taken_DX=1, PC_PIF=0x280, imem_wait=1 for 3 cycles:
  - redirect_pending=1 for 3 cycles, PC_IF held.
  - Then PC_IF=0x280, state RUN, redirect_cnt=1.
- trap_req and jalr_DX both high → PC_src_sel=PC_HANDLER; PC_IF=handler target; redirect_cnt +1 only.
- In HOLD with pend_PC=0x300: trap_req with PC_PIF=0x100, then imem_wait drops → PC_IF=0x100; redirect_cnt +2 total.
- stall_DX=1 with jal_DX=1 → PC_src_sel=PC_REPLAY, PC_IF unchanged, no kill. Assert reset mid-HOLD → PC_IF=0x200 asynchronously, redirect_pending=0.
